// File: rtl/kernel3_gmem_a_m_axi_srl_fifo_ctrl_pkg.sv
// Shared definitions for the gmem_A SRL FIFO controller and its SRL storage.
package kernel3_gmem_a_m_axi_srl_fifo_ctrl_pkg;

  // Output-register state: EMPTY means if_dout holds no valid word.
  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_VALID = 1'b1
  } fifo_state_e;

  // Default geometry of the gmem_A instance.
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_ADDR_WIDTH = 6;
  localparam int DEF_DEPTH      = 63;

  // Occupancy counters need one bit more than the SRL read address.
  localparam int CNT_W = DEF_ADDR_WIDTH + 1;

  // Occupancy counter width for a given SRL address width.
  function automatic int cnt_width(input int addr_width);
    return addr_width + 1;
  endfunction

endpackage

// File: rtl/kernel3_gmem_a_m_axi_srl_fifo_ctrl_srl.sv
// SRL shift storage: new words shift in at slot 0, a read copies any slot
// into the registered output that feeds if_dout.
module kernel3_gmem_a_m_axi_srl_fifo_ctrl_srl
  import kernel3_gmem_a_m_axi_srl_fifo_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DEPTH      = DEF_DEPTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  we,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] dout
);

  // One word of the total capacity lives in the output register.
  localparam int SRL_DEPTH = DEPTH - 1;

  logic [DATA_WIDTH-1:0] mem_q [SRL_DEPTH];
  logic [DATA_WIDTH-1:0] dout_q;
  logic [DATA_WIDTH-1:0] rd_word;

  // Shift a new word into slot 0 on every write.
  // NOTE: the shift array carries no reset; the controller's counters decide
  // which slots are live, so stale contents are never observed and the
  // storage can map onto SRL primitives.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[0] <= din;
      for (int i = 1; i < SRL_DEPTH; i++) begin
        mem_q[i] <= mem_q[i-1];
      end
    end
  end

  // Select the addressed slot; out-of-range addresses read as zero.
  // NOTE: rd_word gets a default before the conditional so no latch is inferred.
  always_comb begin
    rd_word = '0;
    if (int'(raddr) < SRL_DEPTH) begin
      rd_word = mem_q[raddr];
    end
  end

  // Output register: reads see pre-shift contents on a simultaneous write.
  // NOTE: non-blocking assignment so every register samples the pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      dout_q <= '0;
    end else if (re) begin
      dout_q <= rd_word;
    end
  end

  assign dout = dout_q;

endmodule

// File: rtl/kernel3_gmem_a_m_axi_srl_fifo_ctrl.sv
// First-word-fall-through FIFO controller for the gmem_A AXI path. Tracks SRL
// and total occupancy, keeps the output register filled and drives the flags.
module kernel3_gmem_a_m_axi_srl_fifo_ctrl
  import kernel3_gmem_a_m_axi_srl_fifo_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DEPTH      = DEF_DEPTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clk_en,
  input  logic                  if_write,
  input  logic [DATA_WIDTH-1:0] if_din,
  output logic                  if_full_n,
  input  logic                  if_read,
  output logic [DATA_WIDTH-1:0] if_dout,
  output logic                  if_empty_n,
  output logic [ADDR_WIDTH:0]   num_data_valid
);

  localparam int CW = cnt_width(ADDR_WIDTH);

  fifo_state_e   state_q, state_d;
  logic [CW-1:0] srl_cnt_q, srl_cnt_d;
  logic [CW-1:0] num_q, num_d;
  logic [CW-1:0] srl_cnt_m1;

  logic          dout_vld;
  logic          push;
  logic          pop;
  logic          refill;
  logic [ADDR_WIDTH-1:0] srl_raddr;

  // Flags come straight from registers so the producer/consumer see no
  // combinational path through this block.
  assign dout_vld   = (state_q == ST_VALID);
  assign if_empty_n = dout_vld;
  assign if_full_n  = (num_q != CW'(DEPTH));

  // Accepted transfers; clk_en low freezes everything.
  assign push   = clk_en & if_write & if_full_n;
  assign pop    = clk_en & if_read & dout_vld;
  assign refill = clk_en & (srl_cnt_q != '0) & (~dout_vld | pop);

  // Oldest SRL word sits at slot srl_cnt-1; a simultaneous push shifts after
  // the read, so the old count is the right address.
  assign srl_cnt_m1 = srl_cnt_q - CW'(1);
  assign srl_raddr  = srl_cnt_m1[ADDR_WIDTH-1:0];

  // Output-register FSM and counter next-state.
  always_comb begin
    state_d   = state_q;
    srl_cnt_d = srl_cnt_q + CW'(push) - CW'(refill);
    num_d     = num_q + CW'(push) - CW'(pop);
    unique case (state_q)
      ST_EMPTY: if (refill)        state_d = ST_VALID;
      ST_VALID: if (pop & ~refill) state_d = ST_EMPTY;
      default:                     state_d = ST_EMPTY;
    endcase
  end

  // State and counter registers; reset wins over clk_en.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_EMPTY;
      srl_cnt_q <= '0;
      num_q     <= '0;
    end else begin
      state_q   <= state_d;
      srl_cnt_q <= srl_cnt_d;
      num_q     <= num_d;
    end
  end

  assign num_data_valid = num_q;

  kernel3_gmem_a_m_axi_srl_fifo_ctrl_srl #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .DEPTH      (DEPTH)
  ) u_srl (
    .clk   (clk),
    .reset (reset),
    .we    (push),
    .din   (if_din),
    .re    (refill),
    .raddr (srl_raddr),
    .dout  (if_dout)
  );

endmodule

// File: tb/tb_kernel3_gmem_a_m_axi_srl_fifo_ctrl.sv
// Directed bench for the gmem_A SRL FIFO controller (DEPTH 63, 32-bit words).
module tb_kernel3_gmem_a_m_axi_srl_fifo_ctrl;

  logic        clk;
  logic        reset;
  logic        clk_en;
  logic        if_write;
  logic [31:0] if_din;
  logic        if_full_n;
  logic        if_read;
  logic [31:0] if_dout;
  logic        if_empty_n;
  logic [6:0]  num_data_valid;

  int n_checks = 0;
  int n_errors = 0;

  kernel3_gmem_a_m_axi_srl_fifo_ctrl #(
    .DATA_WIDTH (32),
    .ADDR_WIDTH (6),
    .DEPTH      (63)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .clk_en         (clk_en),
    .if_write       (if_write),
    .if_din         (if_din),
    .if_full_n      (if_full_n),
    .if_read        (if_read),
    .if_dout        (if_dout),
    .if_empty_n     (if_empty_n),
    .num_data_valid (num_data_valid)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Drive one cycle of inputs, then settle 1 ns past the edge for sampling.
  task automatic cyc(input logic w, input logic [31:0] d, input logic r);
    if_write = w;
    if_din   = d;
    if_read  = r;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    if_write = 1'b0;
    if_read  = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_count"},   32'(num_data_valid), 32'd0);
    check({tag, "_empty_n"}, 32'(if_empty_n),     32'd0);
    check({tag, "_full_n"},  32'(if_full_n),      32'd1);
    check({tag, "_dout"},    if_dout,             32'd0);
  endtask

  int next_wr;
  int next_rd;

  initial begin
    reset = 1'b1; clk_en = 1'b1;
    if_write = 1'b0; if_read = 1'b0; if_din = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    check_idle("rst");

    // 1: three writes; output valid after the second edge.
    cyc(1'b1, 32'hA0, 1'b0);
    check("t1_empty_after_1", 32'(if_empty_n), 32'd0);
    cyc(1'b1, 32'hA1, 1'b0);
    check("t1_empty_n_after_2", 32'(if_empty_n), 32'd1);
    check("t1_dout_after_2", if_dout, 32'hA0);
    cyc(1'b1, 32'hA2, 1'b0);
    check("t1_dout", if_dout, 32'hA0);
    check("t1_count", 32'(num_data_valid), 32'd3);
    check("t1_full_n", 32'(if_full_n), 32'd1);

    // 2: fill to 63, refused 64th write.
    do_reset();
    for (int i = 0; i < 63; i++) cyc(1'b1, 32'h1000 + 32'(i), 1'b0);
    check("t2_count_full", 32'(num_data_valid), 32'd63);
    check("t2_full_n", 32'(if_full_n), 32'd0);
    check("t2_head", if_dout, 32'h1000);
    cyc(1'b1, 32'hDEAD, 1'b0);
    check("t2_count_after_64th", 32'(num_data_valid), 32'd63);

    // 4: full with simultaneous write and read: pop only.
    cyc(1'b1, 32'hBEEF, 1'b1);
    check("t4_count", 32'(num_data_valid), 32'd62);
    check("t4_full_n", 32'(if_full_n), 32'd1);

    // 2 (cont.): drain the rest in order; neither 0xDEAD nor 0xBEEF may appear.
    for (int i = 1; i < 63; i++) begin
      check("t2_drain_data", if_dout, 32'h1000 + 32'(i));
      check("t2_drain_vld", 32'(if_empty_n), 32'd1);
      cyc(1'b0, 32'h0, 1'b1);
    end
    check("t2_empty_n_end", 32'(if_empty_n), 32'd0);
    check("t2_count_end", 32'(num_data_valid), 32'd0);

    // 3: steady streaming at occupancy 5.
    do_reset();
    for (int i = 0; i < 5; i++) cyc(1'b1, 32'h200 + 32'(i), 1'b0);
    check("t3_count_start", 32'(num_data_valid), 32'd5);
    next_wr = 5;
    next_rd = 0;
    for (int k = 0; k < 200; k++) begin
      check("t3_data", if_dout, 32'h200 + 32'(next_rd));
      check("t3_vld", 32'(if_empty_n), 32'd1);
      cyc(1'b1, 32'h200 + 32'(next_wr), 1'b1);
      next_wr++;
      next_rd++;
      check("t3_count", 32'(num_data_valid), 32'd5);
    end

    // 5: clk_en low with both requests asserted: nothing moves.
    clk_en = 1'b0;
    for (int k = 0; k < 10; k++) begin
      cyc(1'b1, 32'hFFFF, 1'b1);
      check("t5_count", 32'(num_data_valid), 32'd5);
      check("t5_dout", if_dout, 32'h200 + 32'(next_rd));
      check("t5_empty_n", 32'(if_empty_n), 32'd1);
      check("t5_full_n", 32'(if_full_n), 32'd1);
    end
    clk_en = 1'b1;
    cyc(1'b0, 32'h0, 1'b1);
    next_rd++;
    check("t5_resume_data", if_dout, 32'h200 + 32'(next_rd));
    check("t5_resume_count", 32'(num_data_valid), 32'd4);

    // 6: reset at occupancy 20 (with clk_en low, reset still wins).
    do_reset();
    for (int i = 0; i < 20; i++) cyc(1'b1, 32'h300 + 32'(i), 1'b0);
    check("t6_count_pre", 32'(num_data_valid), 32'd20);
    reset  = 1'b1;
    clk_en = 1'b0;
    cyc(1'b0, 32'h0, 1'b0);
    reset  = 1'b0;
    clk_en = 1'b1;
    check_idle("t6");
    cyc(1'b1, 32'h55, 1'b0);
    cyc(1'b0, 32'h0, 1'b0);
    check("t6_new_data", if_dout, 32'h55);
    check("t6_new_vld", 32'(if_empty_n), 32'd1);
    check("t6_new_count", 32'(num_data_valid), 32'd1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
